// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_pipe_reg
//  Description : IF/ID pipeline register with load-use stall, flush squash,
//                sticky syscall halt and a stall watchdog. Define
//                IF_ID_STALL_STATS_EN to build the stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000,
    parameter int                MAX_STALL = 4,
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_if,
    input  logic [DATA_W-1:0] instr_if,
    input  logic              fetch_valid_if,
    input  logic              nop_lock_id,
    input  logic              flush_id,
    input  logic              halt_id,
    output logic [DATA_W-1:0] pc_id,
    output logic [DATA_W-1:0] instr_id,
    output logic              valid_id,
    output logic              pc_write_en,
    output logic              stall_err,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_STALL = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    localparam int                 c_RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAX_STALL);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_pc_id;
    logic [DATA_W-1:0]  r_instr_id;
    logic               r_valid_id;
    logic               r_stall_err;
    logic [c_RUN_W-1:0] r_stall_run;

    logic w_active;
    logic w_stall;
    logic w_halt;
    logic w_do_flush;
    logic w_do_stall;

    // A lock request with an empty ID slot has no bubble to protect.
    assign w_active   = (r_state != c_ST_HALT);
    assign w_stall    = nop_lock_id & r_valid_id;
    assign w_halt     = halt_id & r_valid_id;
    assign w_do_flush = w_active & ~w_halt & flush_id;
    assign w_do_stall = w_active & ~w_halt & ~flush_id & w_stall;

    assign pc_write_en = rst_n & w_active & ~w_stall & ~w_halt;
    assign pc_id       = r_pc_id;
    assign instr_id    = r_instr_id;
    assign valid_id    = r_valid_id;
    assign stall_err   = r_stall_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_EMPTY;
            r_pc_id     <= RESET_PC;
            r_instr_id  <= NOP_INSTR;
            r_valid_id  <= 1'b0;
            r_stall_err <= 1'b0;
            r_stall_run <= '0;
        end else if (w_active) begin
            if (w_halt) begin
                r_state     <= c_ST_HALT;
                r_instr_id  <= NOP_INSTR;
                r_valid_id  <= 1'b0;
                r_stall_run <= '0;
            end else if (flush_id) begin
                r_state     <= c_ST_EMPTY;
                r_instr_id  <= NOP_INSTR;
                r_valid_id  <= 1'b0;
                r_stall_run <= '0;
            end else if (w_stall) begin
                r_state <= c_ST_STALL;
                if (r_stall_run != c_RUN_MAX) begin
                    r_stall_run <= r_stall_run + c_RUN_ONE;
                end
                // This edge brings the run to MAX_STALL (or it is already there).
                if (r_stall_run >= c_RUN_MAX - c_RUN_ONE) begin
                    r_stall_err <= 1'b1;
                end
            end else begin
                r_stall_run <= '0;
                if (fetch_valid_if) begin
                    r_state    <= c_ST_RUN;
                    r_pc_id    <= pc_if;
                    r_instr_id <= instr_if;
                    r_valid_id <= 1'b1;
                end else begin
                    r_state    <= c_ST_EMPTY;
                    r_instr_id <= NOP_INSTR;
                    r_valid_id <= 1'b0;
                end
            end
        end
    end

`ifdef IF_ID_STALL_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_do_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + c_CNT_ONE;
            end
            if (w_do_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + c_CNT_ONE;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_do_stall ^ w_do_flush;
    assign stall_count    = '0;
    assign flush_count    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_pipe_reg
//  Description : Randomized scoreboard bench for the IF/ID pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_reg;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] c_NOP       = 32'h0000_0000;
    localparam int          c_MAX_STALL = 4;
`ifdef IF_ID_STALL_STATS_EN
    localparam bit          c_STATS     = 1'b1;
`else
    localparam bit          c_STATS     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if, instr_if;
    logic        fetch_valid_if, nop_lock_id, flush_id, halt_id;
    logic [31:0] pc_id, instr_id;
    logic        valid_id, pc_write_en, stall_err;
    logic [31:0] stall_count, flush_count;

    if_id_pipe_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_if          (pc_if),
        .instr_if       (instr_if),
        .fetch_valid_if (fetch_valid_if),
        .nop_lock_id    (nop_lock_id),
        .flush_id       (flush_id),
        .halt_id        (halt_id),
        .pc_id          (pc_id),
        .instr_id       (instr_id),
        .valid_id       (valid_id),
        .pc_write_en    (pc_write_en),
        .stall_err      (stall_err),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Reference state: what ID holds and what has happened so far.
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_halted, m_err;
    int          m_run;
    logic [31:0] m_stalls, m_flushes;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = c_RESET_PC; m_instr = c_NOP; m_valid = 1'b0; m_halted = 1'b0;
        m_err = 1'b0; m_run = 0; m_stalls = '0; m_flushes = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_pc_id", pc_id, c_RESET_PC);
        chk("rst_instr_id", instr_id, c_NOP);
        chk("rst_valid_id", 32'(valid_id), 32'd0);
        chk("rst_pc_write_en", 32'(pc_write_en), 32'd0);
        chk("rst_stall_err", 32'(stall_err), 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_flush_count", flush_count, 32'd0);
    endtask

    // One clock of stimulus: drive, check the combinational PC enable,
    // then push what ID must hold after the coming rising edge.
    task automatic cycle(input logic [31:0] pc, input logic [31:0] ins, input logic fv,
                         input logic lock, input logic fl, input logic hl);
        exp_t e;
        logic lock_eff, halt_eff;
        @(negedge clk);
        rst_n = 1'b1;
        pc_if = pc; instr_if = ins; fetch_valid_if = fv;
        nop_lock_id = lock; flush_id = fl; halt_id = hl;
        #1;
        lock_eff = lock && m_valid;
        halt_eff = hl && m_valid;
        chk("pc_write_en", 32'(pc_write_en), 32'(!m_halted && !lock_eff && !halt_eff));
        if (m_halted) begin
            // frozen
        end else if (halt_eff) begin
            m_valid = 1'b0; m_instr = c_NOP; m_halted = 1'b1; m_run = 0;
        end else if (fl) begin
            m_valid = 1'b0; m_instr = c_NOP; m_run = 0;
            if (m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 32'd1;
        end else if (lock_eff) begin
            m_run = m_run + 1;
            if (m_run >= c_MAX_STALL) m_err = 1'b1;
            if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
        end else begin
            m_run = 0;
            if (fv) begin
                m_pc = pc; m_instr = ins; m_valid = 1'b1;
            end else begin
                m_instr = c_NOP; m_valid = 1'b0;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.valid = m_valid; e.err = m_err;
        e.sc = c_STATS ? m_stalls : 32'd0;
        e.fc = c_STATS ? m_flushes : 32'd0;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
    endtask

    // Monitor: every registered output update is compared against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("pc_id", pc_id, mon_e.pc);
                chk("instr_id", instr_id, mon_e.instr);
                chk("valid_id", 32'(valid_id), 32'(mon_e.valid));
                chk("stall_err", 32'(stall_err), 32'(mon_e.err));
                chk("stall_count", stall_count, mon_e.sc);
                chk("flush_count", flush_count, mon_e.fc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; pc_if = '0; instr_if = '0; fetch_valid_if = 1'b0;
        nop_lock_id = 1'b0; flush_id = 1'b0; halt_id = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();

        // First fetch, single stall, then lock and flush on the same edge.
        cycle(32'h0000_3000, 32'h8C08_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h0000_3004, 32'h0109_5020, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(32'h0000_3004, 32'h0109_5020, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h0000_3008, 32'h1000_0003, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(32'h0000_3010, 32'h2008_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        // Watchdog: three stalls stay clean, the fourth trips it.
        for (int i = 0; i < 3; i++) cycle(32'h0000_3014, 32'h2009_0002, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(32'h0000_3014, 32'h2009_0002, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(32'h0000_3014, 32'h2009_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h0000_3018, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Lock while empty is ignored; then halt and try to keep fetching.
        cycle(32'h0000_301C, 32'h2402_000A, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(32'h0000_3020, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle($urandom, $urandom, 1'b1, 1'(i & 1), 1'(i >> 1), 1'b0);
        do_reset();

        // Randomized traffic with occasional mid-run resets.
        for (int n = 0; n < 800; n++) begin
            if ((n % 97) == 96) do_reset();
            cycle($urandom, $urandom,
                  1'($urandom_range(3, 0) != 0),
                  1'($urandom_range(2, 0) == 0),
                  1'($urandom_range(7, 0) == 0),
                  1'($urandom_range(59, 0) == 0));
        end

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
